// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single-ported, pipelined main memory between the I-cache miss
//   handler and the D-cache miss/write-through handler. One requester is
//   granted at a time. A D-side write is a single memory cycle. A block fill
//   issues one read per cycle and routes each returned word to the granted
//   cache, whatever the memory latency.
//
// Optional feature (macro ARB_RR_EN):
//   defined   - when d_req and i_req are both pending in IDLE, the grant goes
//               to the opposite of the last fill grant. d_wr_req always wins.
//   undefined - fixed priority d_wr_req > d_req > i_req.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_req, i_addr       I-cache block fill request / miss address
//   d_req, d_wr_req     D-cache block fill / single-word write requests
//   d_addr, d_wdata     D miss or write address, write data
//   mem_addr            address to main memory
//   mem_enable, mem_wr  memory access strobe, write strobe
//   mem_wdata           memory write data
//   mem_rdata           memory read data
//   mem_valid           mem_rdata valid this cycle
//   i_fill_we           write fill_data into I-cache word fill_word
//   d_fill_we           write fill_data into D-cache word fill_word
//   fill_word           word index of fill_data within the block
//   fill_data           returned word
//   i_done, d_done      one-cycle completion pulses
//   busy                arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W           = 16,
    parameter int DATA_W           = 16,
    parameter int WORDS_PER_BLOCK  = 8,
    localparam int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic [OFF_W-1:0]  fill_word,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DWRITE = 2'd1;
    localparam logic [1:0] S_DFILL  = 2'd2;
    localparam logic [1:0] S_IFILL  = 2'd3;

    localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(WORDS_PER_BLOCK - 1);
    // Block base clears the word offset plus the byte-within-word bit.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'(2 * WORDS_PER_BLOCK - 1));

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [OFF_W-1:0]  r_iss;
    logic [OFF_W-1:0]  r_ret;
    logic              r_issDone;
`ifdef ARB_RR_EN
    logic              r_lastGrantD;
`endif

    logic              w_grantWr;
    logic              w_grantD;
    logic              w_grantI;
    logic              w_fillActive;
    logic              w_issue;
    logic              w_return;
    logic              w_lastReturn;
    logic [ADDR_W-1:0] w_offset;

    // Grant selection, only acted upon while idle.
    always_comb begin
        w_grantWr = 1'b0;
        w_grantD  = 1'b0;
        w_grantI  = 1'b0;
        if (d_wr_req) begin
            w_grantWr = 1'b1;
        end else if (d_req && i_req) begin
`ifdef ARB_RR_EN
            if (r_lastGrantD) begin
                w_grantI = 1'b1;
            end else begin
                w_grantD = 1'b1;
            end
`else
            w_grantD = 1'b1;
`endif
        end else if (d_req) begin
            w_grantD = 1'b1;
        end else if (i_req) begin
            w_grantI = 1'b1;
        end
    end

    assign w_fillActive = (r_state == S_DFILL) || (r_state == S_IFILL);
    assign w_issue      = w_fillActive && !r_issDone;
    assign w_return     = w_fillActive && mem_valid;
    assign w_lastReturn = w_return && (r_ret == LAST_WORD);
    assign w_offset     = {{(ADDR_W - OFF_W - 1){1'b0}}, r_iss, 1'b0};

    // State and counters. Issue and return counters run independently so
    // returns may overlap the issue phase for any memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_iss        <= '0;
            r_ret        <= '0;
            r_issDone    <= 1'b0;
`ifdef ARB_RR_EN
            r_lastGrantD <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_iss     <= '0;
                    r_ret     <= '0;
                    r_issDone <= 1'b0;
                    if (w_grantWr) begin
                        r_state <= S_DWRITE;
                    end else if (w_grantD) begin
                        r_state      <= S_DFILL;
                        r_base       <= d_addr & BASE_MASK;
`ifdef ARB_RR_EN
                        r_lastGrantD <= 1'b1;
`endif
                    end else if (w_grantI) begin
                        r_state      <= S_IFILL;
                        r_base       <= i_addr & BASE_MASK;
`ifdef ARB_RR_EN
                        r_lastGrantD <= 1'b0;
`endif
                    end
                end
                S_DWRITE: begin
                    r_state <= S_IDLE;
                end
                S_DFILL, S_IFILL: begin
                    if (w_issue) begin
                        r_iss <= r_iss + OFF_W'(1);
                        if (r_iss == LAST_WORD) begin
                            r_issDone <= 1'b1;
                        end
                    end
                    if (w_lastReturn) begin
                        r_state   <= S_IDLE;
                        r_ret     <= '0;
                        r_iss     <= '0;
                        r_issDone <= 1'b0;
                    end else if (w_return) begin
                        r_ret <= r_ret + OFF_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from state; all of them read zero when idle, so a
    // stray mem_valid outside a fill never reaches either cache.
    always_comb begin
        mem_addr   = '0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        i_fill_we  = 1'b0;
        d_fill_we  = 1'b0;
        fill_word  = '0;
        fill_data  = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        busy       = (r_state != S_IDLE);
        if (r_state == S_DWRITE) begin
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            d_done     = 1'b1;
        end
        if (w_issue) begin
            mem_enable = 1'b1;
            mem_addr   = r_base | w_offset;
        end
        if (w_return) begin
            fill_word = r_ret;
            fill_data = mem_rdata;
            if (r_state == S_DFILL) begin
                d_fill_we = 1'b1;
                d_done    = w_lastReturn;
            end else begin
                i_fill_we = 1'b1;
                i_done    = w_lastReturn;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A fixed-latency memory model answers
//   the DUT's reads. Expected behaviour is derived per transaction from the
//   service order (write first, then fills by priority or alternation) and a
//   timeline relative to each grant cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS  = 8;
    localparam int OFF_W  = 3;

    localparam int K_WRITE = 0;
    localparam int K_DFILL = 1;
    localparam int K_IFILL = 2;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_enable;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              i_fill_we;
    logic              d_fill_we;
    logic [OFF_W-1:0]  fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              i_done;
    logic              d_done;
    logic              busy;

    int checks     = 0;
    int failures   = 0;
    int cycleNum   = 0;
    int memLat     = 4;
    bit modelLastD = 1'b0;

    typedef struct {
        int                retCycle;
        logic [DATA_W-1:0] data;
    } readT;
    readT pend[$];

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .WORDS_PER_BLOCK(WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .d_req(d_req),
        .d_wr_req(d_wr_req),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .mem_addr(mem_addr),
        .mem_enable(mem_enable),
        .mem_wr(mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .i_fill_we(i_fill_we),
        .d_fill_we(d_fill_we),
        .fill_word(fill_word),
        .fill_data(fill_data),
        .i_done(i_done),
        .d_done(d_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
    endfunction

    function automatic logic [6:0] ctrlVec();
        return {busy, mem_enable, mem_wr, i_fill_we, d_fill_we, i_done, d_done};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cycleNum);
        end
    endtask

    task automatic checkCycle(input string tag, input logic [6:0] eCtrl,
                              input logic [ADDR_W-1:0] eAddr, input logic [DATA_W-1:0] eWdata,
                              input logic [OFF_W-1:0] eWord, input logic [DATA_W-1:0] eData);
        checkOutput({tag, " ctrl"}, 32'(ctrlVec()), 32'(eCtrl));
        checkOutput({tag, " addr"}, 32'(mem_addr), 32'(eAddr));
        checkOutput({tag, " wdata"}, 32'(mem_wdata), 32'(eWdata));
        checkOutput({tag, " fill"}, {13'd0, fill_word, fill_data}, {13'd0, eWord, eData});
    endtask

    // Advance one clock. Reads seen this cycle are queued in the memory model;
    // a reset flushes everything in flight, as the real memory shares rst.
    task automatic nextCycle();
        readT r;
        if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
            r.retCycle = cycleNum + memLat;
            r.data     = memWord(mem_addr);
            pend.push_back(r);
        end
        @(posedge clk);
        cycleNum++;
        if (rst) pend.delete();
        @(negedge clk);
        mem_valid = 1'b0;
        mem_rdata = '0;
        if (pend.size() > 0 && pend[0].retCycle == cycleNum) begin
            mem_valid = 1'b1;
            mem_rdata = pend[0].data;
            void'(pend.pop_front());
        end
        #1;
    endtask

    // Expected outputs t cycles after the grant decision of a block fill.
    task automatic checkFillCycle(input int kind, input logic [ADDR_W-1:0] b, input int t);
        bit en;
        bit v;
        int k;
        logic [6:0] eCtrl;
        en = (t <= WORDS);
        k  = t - 1 - memLat;
        v  = (k >= 0) && (k < WORDS);
        eCtrl = {1'b1, en, 1'b0,
                 v && kind == K_IFILL, v && kind == K_DFILL,
                 v && kind == K_IFILL && k == WORDS - 1,
                 v && kind == K_DFILL && k == WORDS - 1};
        checkCycle(kind == K_IFILL ? "ifill" : "dfill", eCtrl,
                   en ? b + 16'(2 * (t - 1)) : 16'h0, 16'h0,
                   v ? OFF_W'(k) : '0, v ? memWord(b + 16'(2 * k)) : 16'h0);
    endtask

    // Runs one granted transaction; returns in the IDLE cycle after done.
    task automatic runOp(input int kind, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        logic [ADDR_W-1:0] b;
        if (kind == K_WRITE) begin
            nextCycle();
            checkCycle("write", 7'b1110001, addr, wdata, '0, 16'h0);
            nextCycle();
        end else begin
            b = addr & ~(16'(2 * WORDS - 1));
            for (int t = 1; t <= WORDS + memLat; t++) begin
                nextCycle();
                checkFillCycle(kind, b, t);
            end
            nextCycle();
        end
    endtask

    // Raises the chosen requests together and serves them until all are done.
    task automatic applyStimulus(input bit doWr, input bit doD, input bit doI,
                                 input logic [ADDR_W-1:0] wrAddr, input logic [ADDR_W-1:0] dAddr,
                                 input logic [ADDR_W-1:0] iAddr, input logic [DATA_W-1:0] wdata,
                                 input int lat);
        bit pw;
        bit pd;
        bit pi;
        int kind;
        memLat   = lat;
        pw       = doWr;
        pd       = doD;
        pi       = doI;
        d_wr_req = doWr;
        d_req    = doD;
        i_req    = doI;
        i_addr   = iAddr;
        d_wdata  = wdata;
        while (pw || pd || pi) begin
            if (pw) begin
                kind = K_WRITE;
            end else if (pd && pi) begin
`ifdef ARB_RR_EN
                kind = modelLastD ? K_IFILL : K_DFILL;
`else
                kind = K_DFILL;
`endif
            end else if (pd) begin
                kind = K_DFILL;
            end else begin
                kind = K_IFILL;
            end
            if (kind == K_DFILL) modelLastD = 1'b1;
            if (kind == K_IFILL) modelLastD = 1'b0;
            d_addr = (kind == K_WRITE) ? wrAddr : dAddr;
            #1;
            checkCycle("grant idle", 7'b0, 16'h0, 16'h0, '0, 16'h0);
            runOp(kind, (kind == K_IFILL) ? iAddr : d_addr, wdata);
            if (kind == K_WRITE) begin pw = 1'b0; d_wr_req = 1'b0; end
            if (kind == K_DFILL) begin pd = 1'b0; d_req = 1'b0; end
            if (kind == K_IFILL) begin pi = 1'b0; i_req = 1'b0; end
        end
        #1;
        checkCycle("final idle", 7'b0, 16'h0, 16'h0, '0, 16'h0);
    endtask

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        d_req     = 1'b0;
        d_wr_req  = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        #1;
        nextCycle();
        rst = 1'b0;
        #1;
        checkCycle("reset", 7'b0, 16'h0, 16'h0, '0, 16'h0);

        // Stray memory data while idle must be ignored.
        mem_valid = 1'b1;
        mem_rdata = 16'h1234;
        #1;
        checkCycle("stray valid", 7'b0, 16'h0, 16'h0, '0, 16'h0);
        nextCycle();
        checkOutput("stray busy", 32'(busy), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0136, 16'h0, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h2004, 16'h0, 16'h0, 16'hBEEF, 4);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0, 16'h8A42, 16'h1170, 16'h0, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0, 16'h0C0E, 16'hF3F1, 16'h0, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h3F02, 16'h5550, 16'h777E, 16'hCAFE, 5);

        // Reset in the cycle of the third returned word aborts the fill.
        memLat = 3;
        i_addr = 16'h4A5A;
        i_req  = 1'b1;
        #1;
        checkCycle("abort idle", 7'b0, 16'h0, 16'h0, '0, 16'h0);
        for (int t = 1; t <= memLat + 3; t++) begin
            nextCycle();
            checkFillCycle(K_IFILL, 16'h4A50, t);
        end
        rst = 1'b1;
        nextCycle();
        rst        = 1'b0;
        modelLastD = 1'b0;
        #1;
        checkOutput("abort ctrl", 32'(ctrlVec()), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h4A5A, 16'h0, 3);

        for (int s = 0; s < 25; s++) begin
            bit w;
            bit d;
            bit i;
            w = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            i = 1'($urandom_range(0, 1));
            if (!(w || d || i)) i = 1'b1;
            applyStimulus(w, d, i, 16'($urandom), 16'($urandom), 16'($urandom),
                          16'($urandom), int'($urandom_range(1, 6)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
